ahb_slave_mem: RTL and testbench

// - AHB-lite responder: the target end of the transfers issued by ahb_master.
// - Decodes an address window and holds a word-addressed RAM.
// - Drives hreadyout, hresp and hrdata, with programmable wait states and a two-cycle ERROR response.
// - Serves as the bench target for ahb_master and as the AHB-side reference for the bridge.

---
 rtl/ahb_pkg.sv | 20 ++
 rtl/slave_ram_1r1w.sv | 28 ++
 rtl/ahb_slave_mem.sv | 106 ++++++++++
 tb/tb_ahb_slave_mem.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings and the responder state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slv_state_e;

endpackage

// File: rtl/slave_ram_1r1w.sv
// Word RAM with one synchronous write port and one registered read port;
// a read of the address being written returns the incoming write data.
module slave_ram_1r1w #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-lite memory responder: window decode, wait-state/error FSM and a
// word-addressed RAM whose registered read port drives hrdata directly.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter logic [31:0] WIN_BYTES   = 32'h0001_0000,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hwrite,
  input  logic        hreadyin,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic [1:0]  hresp
);

  localparam int         AW = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  slv_state_e    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          write_p1;
  logic [AW-1:0] idx_p1;

  logic          capture;
  logic          in_win_p0;
  logic [AW-1:0] idx_p0;
  logic          we;
  logic          re;
  logic          unused_htrans0;

  // Address phase (p0): qualify and decode the transfer on the bus
  assign capture   = hreadyin && htrans[1] && hreadyout;
  assign in_win_p0 = ((haddr & ~(WIN_BYTES - 32'd1)) == BASE_ADDR);
  assign idx_p0    = haddr[AW+1:2];
  assign unused_htrans0 = htrans[0];

  // Data phase (p1): response decode and RAM access
  assign hreadyout = (state_q != ST_WAIT) && (state_q != ST_ERR1);
  assign hresp     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign we        = (state_q == ST_DATA) && write_p1;
  assign re        = capture && in_win_p0 && !hwrite;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      write_p1 <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) write_p1 <= hwrite && in_win_p0;
    end
  end

  always_ff @(posedge hclk) begin
    if (capture) idx_p1 <= idx_p0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_DATA;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all end a phase and may accept the next one
        state_d = ST_IDLE;
        if (capture) begin
          if (!in_win_p0) begin
            state_d = ST_ERR1;
          end else if (WS == 4'd0) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WS;
          end
        end
      end
    endcase
  end

  slave_ram_1r1w #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (hclk),
    .rst_n (hresetn),
    .we    (we),
    .waddr (idx_p1),
    .wdata (hwdata),
    .re    (re),
    .raddr (idx_p0),
    .rdata (hrdata)
  );

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Randomized bench for ahb_slave_mem: one zero-wait and one three-wait instance
// checked against a transaction-level memory model.
module tb_ahb_slave_mem;
  import ahb_pkg::*;

  logic        hclk = 1'b0;
  logic        hresetn   [2];
  logic        hwrite    [2];
  logic        hreadyin  [2];
  logic [1:0]  htrans    [2];
  logic [31:0] haddr     [2];
  logic [31:0] hwdata    [2];
  logic [31:0] hrdata    [2];
  logic        hreadyout [2];
  logic [1:0]  hresp     [2];

  always #5 hclk = ~hclk;

  ahb_slave_mem #(.WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hresetn(hresetn[0]), .hwrite(hwrite[0]), .hreadyin(hreadyin[0]),
    .htrans(htrans[0]), .haddr(haddr[0]), .hwdata(hwdata[0]), .hrdata(hrdata[0]),
    .hreadyout(hreadyout[0]), .hresp(hresp[0])
  );

  ahb_slave_mem #(.WAIT_STATES(3)) u_dut3 (
    .hclk(hclk), .hresetn(hresetn[1]), .hwrite(hwrite[1]), .hreadyin(hreadyin[1]),
    .htrans(htrans[1]), .haddr(haddr[1]), .hwdata(hwdata[1]), .hrdata(hrdata[1]),
    .hreadyout(hreadyout[1]), .hresp(hresp[1])
  );

  // Reference model: memory contents and last read data, per instance
  logic [31:0] mdl     [2][256];
  logic [31:0] last_rd [2];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  task automatic chk_idle(input int k, input string tag);
    chk({tag, "_rdy"},  32'(hreadyout[k]), 32'd1);
    chk({tag, "_resp"}, 32'(hresp[k]),     32'(HRESP_OKAY));
  endtask

  // One isolated transfer: address phase, data phase (with waits), then one idle cycle
  task automatic xfer(input int k, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    int         nlow;
    int         idx;
    logic       win;
    logic [1:0] resp0;
    win = ((addr & 32'hFFFF_0000) == 32'h8000_0000);
    idx = int'(addr[9:2]);
    hwrite[k] = wr; haddr[k] = addr; htrans[k] = HTRANS_NONSEQ; hreadyin[k] = 1'b1;
    tick();
    htrans[k] = HTRANS_IDLE; hwdata[k] = wd; haddr[k] = $urandom; hwrite[k] = 1'($urandom);
    resp0 = hresp[k];
    nlow  = 0;
    while (hreadyout[k] !== 1'b1 && nlow < 20) begin
      nlow++;
      // bus activity while stalled must be ignored
      htrans[k] = HTRANS_NONSEQ; haddr[k] = 32'h9000_0000;
      tick();
    end
    htrans[k] = HTRANS_IDLE;
    chk("waits", 32'(nlow), win ? 32'(ws_of(k)) : 32'd1);
    if (!win) begin
      chk("err_resp1", 32'(resp0), 32'(HRESP_ERROR));
      chk("err_resp2", 32'(hresp[k]), 32'(HRESP_ERROR));
      chk("err_rd_hold", hrdata[k], last_rd[k]);
    end else begin
      chk("resp", 32'(hresp[k]), 32'(HRESP_OKAY));
      if (!wr) begin
        chk("rdata", hrdata[k], mdl[k][idx]);
        last_rd[k] = mdl[k][idx];
      end else begin
        chk("wr_rd_hold", hrdata[k], last_rd[k]);
        mdl[k][idx] = wd;
      end
    end
    tick();
    chk_idle(k, "post");
  endtask

  // Zero-wait instance: write, then a read of the same word in the write's data phase
  task automatic hazard(input logic [31:0] waddr, input logic [31:0] raddr, input logic [31:0] wd);
    hwrite[0] = 1'b1; haddr[0] = waddr; htrans[0] = HTRANS_NONSEQ; hreadyin[0] = 1'b1;
    tick();
    chk("hz_rdy_wr", 32'(hreadyout[0]), 32'd1);
    hwdata[0] = wd; hwrite[0] = 1'b0; haddr[0] = raddr; htrans[0] = HTRANS_NONSEQ;
    tick();
    htrans[0] = HTRANS_IDLE;
    mdl[0][waddr[9:2]] = wd;
    last_rd[0] = wd;
    chk("hz_rdy", 32'(hreadyout[0]), 32'd1);
    chk("hz_resp", 32'(hresp[0]), 32'(HRESP_OKAY));
    chk("hz_rdata", hrdata[0], wd);
    tick();
    chk_idle(0, "hz_post");
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    for (int k = 0; k < 2; k++) begin
      hresetn[k] = 1'b0; hwrite[k] = 1'b0; hreadyin[k] = 1'b1;
      htrans[k] = HTRANS_IDLE; haddr[k] = '0; hwdata[k] = '0; last_rd[k] = '0;
    end
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      chk_idle(k, "rst");
      chk("rst_rdata", hrdata[k], 32'd0);
      hresetn[k] = 1'b1;
    end
    repeat (5) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        chk_idle(k, "rel");
        chk("rel_rdata", hrdata[k], 32'd0);
      end
    end

    // Single write then read, zero wait
    xfer(0, 1'b1, 32'h8000_0011, 32'h8000_0CCC);
    xfer(0, 1'b0, 32'h8000_0010, 32'h0);
    // Back-to-back hazard
    hazard(32'h8000_0020, 32'h8000_0020, 32'hDEAD_BEEF);
    // Three wait states
    xfer(1, 1'b1, 32'h8000_0010, 32'h8000_0CCC);
    xfer(1, 1'b0, 32'h8000_0010, 32'h0);
    // Out of window
    xfer(0, 1'b0, 32'h9000_0000, 32'h0);
    xfer(0, 1'b1, 32'h8000_03FC, 32'h0BAD_F00D);
    xfer(0, 1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF);
    xfer(0, 1'b0, 32'h8000_03FC, 32'h0);

    // Reset in the second wait cycle of a write
    xfer(1, 1'b1, 32'h8000_0040, 32'hA5A5_0040);
    hwrite[1] = 1'b1; haddr[1] = 32'h8000_0040; htrans[1] = HTRANS_NONSEQ;
    tick();
    htrans[1] = HTRANS_IDLE; hwdata[1] = 32'h1234_5678;
    chk("mid_wait1", 32'(hreadyout[1]), 32'd0);
    tick();
    chk("mid_wait2", 32'(hreadyout[1]), 32'd0);
    hresetn[1] = 1'b0;
    #1;
    chk_idle(1, "mid_rst");
    chk("mid_rst_rdata", hrdata[1], 32'd0);
    tick();
    tick();
    hresetn[1] = 1'b1;
    last_rd[1] = '0;
    tick();
    xfer(1, 1'b0, 32'h8000_0040, 32'h0);

    // Known contents for the random phase
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++)
        xfer(k, 1'b1, 32'h8000_0000 | 32'(i << 2), $urandom);

    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 40; n++) begin
        r = $urandom_range(0, 9);
        if (r == 0) begin
          // unqualified transfer: BUSY, or NONSEQ without hreadyin
          if ($urandom_range(0, 1) == 0) begin
            htrans[k] = HTRANS_BUSY; hreadyin[k] = 1'b1;
          end else begin
            htrans[k] = HTRANS_NONSEQ; hreadyin[k] = 1'b0;
          end
          haddr[k] = 32'h9000_0000; hwrite[k] = 1'b0;
          tick();
          htrans[k] = HTRANS_IDLE; hreadyin[k] = 1'b1;
          tick();
          chk_idle(k, "noop");
        end else if (r == 1) begin
          a = $urandom;
          if ((a & 32'hFFFF_0000) == 32'h8000_0000) a = a ^ 32'h1000_0000;
          xfer(k, 1'($urandom), a, $urandom);
        end else begin
          a = 32'h8000_0000 | 32'($urandom_range(0, 63) << 10)
            | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
          xfer(k, 1'($urandom), a, $urandom);
        end
      end
    end

    for (int n = 0; n < 8; n++) begin
      a = 32'h8000_0000 | 32'($urandom_range(0, 15) << 2);
      hazard(a, a | 32'($urandom_range(0, 63) << 10), $urandom);
      xfer(0, 1'b0, a, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
